// File: rtl/multi_digit_display.sv
// N-digit multiplexed seven-segment driver: hex decode, per-digit dp, PWM brightness,
// leading-zero suppression and frame-synchronous input shadowing.
module multi_digit_display #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned PRESCALE_BITS = 15,
  parameter int unsigned BRIGHT_BITS   = 3,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*DIGITS-1:0]    number,
  input  logic [DIGITS-1:0]      dp_in,
  input  logic                   zero_suppress,
  input  logic [BRIGHT_BITS-1:0] brightness,
  input  logic                   blank,
  output logic [DIGITS-1:0]      anodes,
  output logic [6:0]             segments,
  output logic                   dp,
  output logic                   frame_start
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NUM_W = 4 * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [PRESCALE_BITS-1:0] prescaler;
  logic [IDX_W-1:0]         index;
  logic                     started;

  logic [NUM_W-1:0]         number_sh;
  logic [DIGITS-1:0]        dp_sh;
  logic                     zs_sh;
  logic [BRIGHT_BITS-1:0]   bright_sh;

  logic                     load_c;
  logic [7:0]               shamt_c;
  logic [NUM_W-1:0]         upper_c;
  logic [3:0]               nibble_c;
  logic                     suppress_c;
  logic                     lit_c;
  logic [6:0]               seg_low_c;
  logic [DIGITS-1:0]        anode_on_c;
  logic                     dp_on_c;

  // First post-reset cycle is a load-only cycle, so every frame is exactly DIGITS slots.
  assign load_c = !started || ((prescaler == '1) && (index == LAST_IDX));

  // Slot prescaler and digit index
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      index     <= '0;
      started   <= 1'b0;
    end else if (!started) begin
      started   <= 1'b1;
    end else begin
      prescaler <= prescaler + PRESCALE_BITS'(1);
      if (prescaler == '1) begin
        if (index == LAST_IDX) index <= '0;
        else                   index <= index + IDX_W'(1);
      end
    end
  end

  // Shadow registers, reloaded only at frame boundaries to avoid tearing
  always_ff @(posedge clock) begin
    if (reset) begin
      number_sh   <= '0;
      dp_sh       <= '0;
      zs_sh       <= 1'b0;
      bright_sh   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load_c;
      if (load_c) begin
        number_sh <= number;
        dp_sh     <= dp_in;
        zs_sh     <= zero_suppress;
        bright_sh <= brightness;
      end
    end
  end

  // Digit decode; upper_c holds nibbles 0..index, so zero means all leading digits are zero
  always_comb begin
    shamt_c    = 8'(4 * (int'(DIGITS) - 1 - int'(index)));
    upper_c    = number_sh >> shamt_c;
    nibble_c   = upper_c[3:0];
    suppress_c = zs_sh && (upper_c == '0) && (index != LAST_IDX);
    lit_c      = (prescaler[PRESCALE_BITS-1 -: BRIGHT_BITS] <= bright_sh)
                 && !suppress_c && !blank;
    anode_on_c = lit_c ? (DIGITS'(1) << index) : '0;
    dp_on_c    = dp_sh[index] && !suppress_c;
    case (nibble_c)
      4'h0: seg_low_c = 7'b1000000;
      4'h1: seg_low_c = 7'b1111001;
      4'h2: seg_low_c = 7'b0100100;
      4'h3: seg_low_c = 7'b0110000;
      4'h4: seg_low_c = 7'b0011001;
      4'h5: seg_low_c = 7'b0010010;
      4'h6: seg_low_c = 7'b0000010;
      4'h7: seg_low_c = 7'b1011000;
      4'h8: seg_low_c = 7'b0000000;
      4'h9: seg_low_c = 7'b0010000;
      4'hA: seg_low_c = 7'b0001000;
      4'hB: seg_low_c = 7'b0000011;
      4'hC: seg_low_c = 7'b1000110;
      4'hD: seg_low_c = 7'b0100001;
      4'hE: seg_low_c = 7'b0000110;
      default: seg_low_c = 7'b0001110;
    endcase
  end

  // Registered pin drivers with polarity selection
  always_ff @(posedge clock) begin
    if (reset) begin
      anodes   <= {DIGITS{ACTIVE_LOW}};
      segments <= {7{ACTIVE_LOW}};
      dp       <= ACTIVE_LOW;
    end else begin
      anodes   <= ACTIVE_LOW ? ~anode_on_c : anode_on_c;
      segments <= ACTIVE_LOW ? seg_low_c : ~seg_low_c;
      dp       <= ACTIVE_LOW ? ~dp_on_c : dp_on_c;
    end
  end

endmodule

// File: tb/tb_multi_digit_display.sv
// Randomized bench for multi_digit_display with a cycle-count based reference model
// and a few hand-computed anchor checks.
module tb_multi_digit_display;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] number = '0;
  logic [3:0]  dp_in = '0;
  logic        zero_suppress = 1'b0;
  logic [1:0]  brightness = '0;
  logic        blank = 1'b0;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;

  multi_digit_display #(
    .DIGITS(4), .PRESCALE_BITS(4), .BRIGHT_BITS(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clk), .reset(reset), .number(number), .dp_in(dp_in),
    .zero_suppress(zero_suppress), .brightness(brightness), .blank(blank),
    .anodes(anodes), .segments(segments), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: m_c counts clocks since the first post-release load; slot/phase derive from it.
  bit        m_valid = 1'b0;
  bit        m_started;
  int        m_c;
  logic [15:0] sh_num;
  logic [3:0]  sh_dp;
  logic        sh_zs;
  logic [1:0]  sh_br;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fs;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_started = 1'b0; m_c = 0;
      sh_num = '0; sh_dp = '0; sh_zs = 1'b0; sh_br = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else if (m_valid) begin
      int slot, phase, upper;
      bit supp, lit, load;
      slot  = (m_c / 16) % 4;
      phase = m_c % 16;
      upper = int'(sh_num) >> (4 * (3 - slot));
      supp  = sh_zs && (slot < 3) && (upper == 0);
      lit   = ((phase / 4) <= int'(sh_br)) && !supp && !blank;
      exp_an  = lit ? ~(4'b0001 << slot) : 4'hF;
      exp_seg = SEG[upper % 16];
      exp_dp  = !(sh_dp[slot] && !supp);
      if (!m_started) begin
        m_started = 1'b1;
        load = 1'b1;
      end else begin
        m_c++;
        load = (m_c % 64 == 0);
      end
      if (load) begin
        sh_num = number; sh_dp = dp_in; sh_zs = zero_suppress; sh_br = brightness;
      end
      exp_fs = load;
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("anodes", 32'(anodes), 32'(exp_an));
      check("segments", 32'(segments), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
    end
  end

  task automatic wait_fs();
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_frame_start: got timeout expected pulse within 200 cycles");
    end
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check("reset_anodes", 32'(anodes), 32'h0000000F);
    check("reset_segments", 32'(segments), 32'h0000007F);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_fs", 32'(frame_start), 32'h0);

    @(negedge clk);
    number = 16'h12AF; brightness = 2'd3; reset = 1'b0;
    @(posedge clk); #1;
    check("release_fs_high", 32'(frame_start), 32'h1);
    @(posedge clk); #1;
    check("release_fs_low", 32'(frame_start), 32'h0);
    check("slot0_an", 32'(anodes), 32'h0000000E);
    check("slot0_seg", 32'(segments), 32'(7'b1111001));
    repeat (16) @(posedge clk); #1;
    check("slot1_an", 32'(anodes), 32'h0000000D);
    check("slot1_seg", 32'(segments), 32'(7'b0100100));
    repeat (16) @(posedge clk); #1;
    check("slot2_an", 32'(anodes), 32'h0000000B);
    check("slot2_seg", 32'(segments), 32'(7'b0001000));
    repeat (16) @(posedge clk); #1;
    check("slot3_an", 32'(anodes), 32'h00000007);
    check("slot3_seg", 32'(segments), 32'(7'b0001110));
    check("slot3_dp", 32'(dp), 32'h1);
    repeat (15) @(posedge clk); #1;
    check("fs_period64", 32'(frame_start), 32'h1);

    // Leading-zero suppression
    @(negedge clk);
    zero_suppress = 1'b1; number = 16'h0005;
    wait_fs();
    @(posedge clk); #1;
    check("zs_slot0_off", 32'(anodes), 32'h0000000F);
    repeat (48) @(posedge clk); #1;
    check("zs_slot3_an", 32'(anodes), 32'h00000007);
    check("zs_slot3_seg", 32'(segments), 32'(7'b0010010));

    // Decimal point in slot 2
    @(negedge clk);
    zero_suppress = 1'b0; number = 16'h3456; dp_in = 4'b0100;
    wait_fs();
    repeat (33) @(posedge clk); #1;
    check("dp_slot2", 32'(dp), 32'h0);

    // Dimmest duty: 4 of 16 slot cycles
    @(negedge clk);
    brightness = 2'd0; dp_in = '0;
    wait_fs();
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (anodes[0] == 1'b0) cnt++;
    end
    check("duty_b0", 32'(cnt), 32'd4);

    // Randomized phase, model checks every cycle
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0)
        for (int n = 0; n < 4; n++)
          number[4*n +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(15) == 0) zero_suppress = 1'($urandom);
      if ($urandom_range(15) == 0) brightness = 2'($urandom);
      blank = ($urandom_range(15) == 0);
      reset = ($urandom_range(699) == 0);
    end
    @(negedge clk);
    reset = 1'b0; blank = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
